// File: rtl/oam_dma_arbiter_pkg.sv
// rtl/oam_dma_arbiter_pkg.sv - shared types and constants for the OAM DMA arbiter
//
// Purpose: DMA sequencer state encoding and the default address map
// constants used by oam_dma_arbiter and dma_addr_gen.
// Ports: none (package).

package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DmaIdle  = 2'd0,
    DmaStart = 2'd1,
    DmaXfer  = 2'd2
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
  localparam int          OAM_LEN_DEFAULT      = 160;
  localparam logic [15:0] HIGH_BUS_BASE        = 16'hFF00;

endpackage

// File: rtl/oam_dma_arbiter_dma_addr_gen.sv
// rtl/oam_dma_arbiter_dma_addr_gen.sv - DMA byte index, latched source page and echo remap
//
// Purpose: holds the running byte index and the source page latched at
// transfer start, and forms the external read address from them.
// Build option: OAM_DMA_ECHO_REMAP_EN folds source pages E0-FF down by 0x20.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          restart: idx <= 0, xfer_src <= src_i
//   step_i          a byte was copied this M-cycle; advance idx
//   src_i           source page register
//   idx_o           current byte index
//   dma_addr_o      {effective source page, idx}
//   last_o          idx is the final byte of the transfer

module dma_addr_gen
  import oam_dma_arbiter_pkg::*;
#(
  parameter int OAM_LEN = OAM_LEN_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [7:0]  src_i,
  output logic [7:0]  idx_o,
  output logic [15:0] dma_addr_o,
  output logic        last_o
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  logic [7:0] idx_q, idx_d;
  logic [7:0] xfer_src_q, xfer_src_d;
  logic [7:0] src_eff;

  assign last_o = (idx_q == LAST_IDX);

  // Load wins over step: on a restart the carried byte is written with the
  // old index in the same M-cycle the new transfer is loaded.
  always_comb begin
    idx_d      = idx_q;
    xfer_src_d = xfer_src_q;
    if (load_i) begin
      idx_d      = 8'd0;
      xfer_src_d = src_i;
    end else if (step_i && !last_o) begin
      idx_d = idx_q + 8'd1;
    end
  end

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign src_eff = (xfer_src_q >= 8'hE0) ? (xfer_src_q - 8'h20) : xfer_src_q;
`else
  assign src_eff = xfer_src_q;
`endif

  assign idx_o      = idx_q;
  assign dma_addr_o = {src_eff, idx_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= 8'd0;
      xfer_src_q <= 8'hFF;
    end else begin
      idx_q      <= idx_d;
      xfer_src_q <= xfer_src_d;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - OAM DMA sequencer and CPU/DMA memory bus arbiter
//
// Purpose: sequences the OAM copy started by a CPU write to DMA_REG_ADDR and
// routes CPU accesses to the external bus (0000-FEFF) or the high bus
// (FF00-FFFF). While DMA owns the external bus, CPU accesses below FF00 read
// 8'hFF and writes are dropped. Steps on t_cycle==3 (end of an M-cycle).
// Build option: OAM_DMA_ECHO_REMAP_EN (echo remap of source pages E0-FF).
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   t_cycle                       T-cycle phase, 3 = last of the M-cycle
//   cpu_mem_enable/_write, cpu_addr, cpu_data_out, cpu_data_in   CPU side
//   ext_enable/_write/_addr/_data_out, ext_data_in               0000-FEFF bus
//   hi_enable/_write/_addr/_data_out, hi_data_in                 FF00-FFFF bus
//   oam_write, oam_addr, oam_data                               OAM write port
//   dma_active                    external bus owned by DMA

module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          OAM_LEN      = OAM_LEN_DEFAULT,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic        ext_enable,
  output logic        ext_write,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_data_out,
  input  logic [7:0]  ext_data_in,
  output logic        hi_enable,
  output logic        hi_write,
  output logic [15:0] hi_addr,
  output logic [7:0]  hi_data_out,
  input  logic [7:0]  hi_data_in,
  output logic        oam_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        dma_active
);

  dma_state_e state_q, state_d;
  logic       restart_q, restart_d;  // DmaStart entered with bytes still pending
  logic [7:0] src_q, src_d;

  logic        t3;
  logic        is_reg, is_hi, is_ext;
  logic        reg_wr;
  logic        dma_busy;
  logic        gen_load, gen_step, gen_last;
  logic [7:0]  gen_idx;
  logic [15:0] gen_addr;

  assign t3     = (t_cycle == 2'd3);
  assign is_reg = (cpu_addr == DMA_REG_ADDR);
  assign is_hi  = (cpu_addr >= HIGH_BUS_BASE) && !is_reg;
  assign is_ext = (cpu_addr < HIGH_BUS_BASE);
  assign reg_wr = cpu_mem_enable && cpu_mem_write && is_reg && t3;

  // A restart M-cycle still copies one byte of the old transfer.
  assign dma_busy = (state_q == DmaXfer) || ((state_q == DmaStart) && restart_q);

  assign gen_load = (state_q == DmaStart) && t3;
  assign gen_step = dma_busy && t3;

  dma_addr_gen #(
    .OAM_LEN (OAM_LEN)
  ) u_addr_gen (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (gen_load),
    .step_i     (gen_step),
    .src_i      (src_q),
    .idx_o      (gen_idx),
    .dma_addr_o (gen_addr),
    .last_o     (gen_last)
  );

  always_comb begin
    state_d   = state_q;
    restart_d = restart_q;
    src_d     = src_q;
    if (t3) begin
      case (state_q)
        DmaStart: begin
          state_d   = DmaXfer;
          restart_d = 1'b0;
        end
        DmaXfer: begin
          if (gen_last) state_d = DmaIdle;
        end
        default: ;
      endcase
      // A register write restarts from any state; only an unfinished
      // transfer in DmaXfer carries a byte into the DmaStart M-cycle.
      if (reg_wr) begin
        src_d     = cpu_data_out;
        state_d   = DmaStart;
        restart_d = (state_q == DmaXfer) && !gen_last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DmaIdle;
      restart_q <= 1'b0;
      src_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      restart_q <= restart_d;
      src_q     <= src_d;
    end
  end

  // Outputs are forced low while reset_n is asserted, independent of clk.
  always_comb begin
    cpu_data_in  = 8'h00;
    ext_enable   = 1'b0;
    ext_write    = 1'b0;
    ext_addr     = 16'h0000;
    ext_data_out = 8'h00;
    hi_enable    = 1'b0;
    hi_write     = 1'b0;
    hi_addr      = 16'h0000;
    hi_data_out  = 8'h00;
    oam_write    = 1'b0;
    oam_addr     = 8'h00;
    oam_data     = 8'h00;
    dma_active   = 1'b0;
    if (reset_n) begin
      dma_active  = dma_busy;
      hi_enable   = cpu_mem_enable && is_hi;
      hi_write    = cpu_mem_enable && cpu_mem_write && is_hi;
      hi_addr     = cpu_addr;
      hi_data_out = cpu_data_out;
      if (dma_busy) begin
        ext_enable = 1'b1;
        ext_addr   = gen_addr;
        if (t3) begin
          oam_write = 1'b1;
          oam_addr  = gen_idx;
          oam_data  = ext_data_in;
        end
      end else begin
        ext_enable   = cpu_mem_enable && is_ext;
        ext_write    = cpu_mem_enable && cpu_mem_write && is_ext;
        ext_addr     = cpu_addr;
        ext_data_out = cpu_data_out;
      end
      if (is_reg)         cpu_data_in = src_q;
      else if (is_hi)     cpu_data_in = hi_data_in;
      else if (!dma_busy) cpu_data_in = ext_data_in;
      else                cpu_data_in = 8'hFF;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - randomized self-checking bench for oam_dma_arbiter
//
// Purpose: drives M-cycles of CPU accesses and compares the arbiter outputs
// against a per-M-cycle schedule of DMA byte slots kept in a queue.
// Build option: OAM_DMA_ECHO_REMAP_EN (must match the RTL build).
// Ports: none (top-level bench).

module tb_oam_dma_arbiter;

  localparam int LEN = 160;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  t_cycle = 2'd0;
  logic        cpu_mem_enable = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic [7:0]  cpu_data_in;
  logic        ext_enable, ext_write;
  logic [15:0] ext_addr;
  logic [7:0]  ext_data_out;
  logic [7:0]  ext_data_in = 8'h00;
  logic        hi_enable, hi_write;
  logic [15:0] hi_addr;
  logic [7:0]  hi_data_out;
  logic [7:0]  hi_data_in = 8'h00;
  logic        oam_write;
  logic [7:0]  oam_addr, oam_data;
  logic        dma_active;

  oam_dma_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .t_cycle        (t_cycle),
    .cpu_mem_enable (cpu_mem_enable),
    .cpu_mem_write  (cpu_mem_write),
    .cpu_addr       (cpu_addr),
    .cpu_data_out   (cpu_data_out),
    .cpu_data_in    (cpu_data_in),
    .ext_enable     (ext_enable),
    .ext_write      (ext_write),
    .ext_addr       (ext_addr),
    .ext_data_out   (ext_data_out),
    .ext_data_in    (ext_data_in),
    .hi_enable      (hi_enable),
    .hi_write       (hi_write),
    .hi_addr        (hi_addr),
    .hi_data_out    (hi_data_out),
    .hi_data_in     (hi_data_in),
    .oam_write      (oam_write),
    .oam_addr       (oam_addr),
    .oam_data       (oam_data),
    .dma_active     (dma_active)
  );

  always #5 clk = ~clk;

  // One entry per upcoming M-cycle: either a bus-idle start slot or a byte
  // copy (page, idx). carried marks the byte finished during a restart.
  typedef struct packed {
    logic       carried;
    logic       start;
    logic [7:0] page;
    logic [7:0] idx;
  } slot_t;

  slot_t      sched[$];
  logic [7:0] m_src = 8'hFF;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] eff_page(input logic [7:0] p);
    logic [7:0] r;
    r = p;
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (int'(p) >= 224) r = 8'(int'(p) - 32);
`endif
    return r;
  endfunction

  task automatic model_after(input bit reg_wr, input logic [7:0] d);
    slot_t cur, keep;
    bit    had;
    had = 0;
    cur = '0;
    if (sched.size() > 0) begin
      cur = sched.pop_front();
      had = 1;
    end
    if (reg_wr) begin
      m_src = d;
      if (had && !cur.start && !cur.carried && sched.size() > 0) begin
        keep = sched[0];
        keep.carried = 1'b1;
        sched.delete();
        sched.push_back(keep);
      end else begin
        sched.delete();
        sched.push_back(slot_t'{1'b0, 1'b1, 8'h00, 8'h00});
      end
      for (int i = 0; i < LEN; i++) sched.push_back(slot_t'{1'b0, 1'b0, d, 8'(i)});
    end
  endtask

  // One M-cycle; inputs are held for all four T-cycles.
  task automatic mcycle(input bit en, input bit wr, input logic [15:0] a, input logic [7:0] d);
    slot_t      s;
    bit         busy, exp_ext, exp_hi;
    logic [7:0] ed, hd, exp_rd;
    s = '0;
    if (sched.size() > 0) s = sched[0];
    busy = (sched.size() > 0) && !s.start;
    ed = 8'($urandom);
    hd = 8'($urandom);
    cpu_mem_enable = en;
    cpu_mem_write  = wr;
    cpu_addr       = a;
    cpu_data_out   = d;
    ext_data_in    = ed;
    hi_data_in     = hd;
    for (int t = 0; t < 4; t++) begin
      t_cycle = 2'(t);
      if (t == 1) begin
        @(negedge clk);
        check_eq("oam_write_mid", oam_write, 0);
      end
      if (t == 3) begin
        @(negedge clk);
        check_eq("dma_active", dma_active, busy);
        if (busy) begin
          check_eq("ext_enable_dma", ext_enable, 1);
          check_eq("ext_write_dma", ext_write, 0);
          check_eq("ext_addr_dma", ext_addr, {eff_page(s.page), s.idx});
          check_eq("oam_write", oam_write, 1);
          check_eq("oam_addr", oam_addr, s.idx);
          check_eq("oam_data", oam_data, ed);
        end else begin
          exp_ext = en && (a < 16'hFF00);
          check_eq("ext_enable_cpu", ext_enable, exp_ext);
          check_eq("ext_write_cpu", ext_write, exp_ext && wr);
          check_eq("oam_write_idle", oam_write, 0);
          if (exp_ext) check_eq("ext_addr_cpu", ext_addr, a);
          if (exp_ext && wr) check_eq("ext_data_out", ext_data_out, d);
        end
        exp_hi = en && (a >= 16'hFF00) && (a != 16'hFF46);
        check_eq("hi_enable", hi_enable, exp_hi);
        check_eq("hi_write", hi_write, exp_hi && wr);
        if (exp_hi) check_eq("hi_addr", hi_addr, a);
        if (a == 16'hFF46)      exp_rd = m_src;
        else if (a >= 16'hFF00) exp_rd = hd;
        else if (busy)          exp_rd = 8'hFF;
        else                    exp_rd = ed;
        check_eq("cpu_data_in", cpu_data_in, exp_rd);
      end
      @(posedge clk);
      #1;
    end
    model_after(en && wr && (a == 16'hFF46), d);
  endtask

  // Background CPU traffic that never touches the DMA register.
  task automatic bg_op(input int k);
    case (k % 4)
      0:       mcycle(1, 0, 16'h0150, 8'h00);
      1:       mcycle(1, 0, 16'hFF80, 8'h00);
      2:       mcycle(1, 1, 16'hC000, 8'h5A);
      default: mcycle(0, 0, 16'h0000, 8'h00);
    endcase
  endtask

  task automatic run_until_idx(input logic [7:0] target);
    int n;
    n = 0;
    while (!(sched.size() > 0 && !sched[0].start && sched[0].idx == target) && n < 400) begin
      bg_op(n);
      n++;
    end
    check_eq("wait_idx_bound", n < 400, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sched.size() > 0 && n < 400) begin
      bg_op(n);
      n++;
    end
    check_eq("drain_bound", n < 400, 1);
  endtask

  task automatic rand_op();
    int          k;
    bit          en, wr;
    logic [15:0] a;
    logic [7:0]  d;
    k  = int'($urandom_range(0, 199));
    en = ($urandom_range(0, 3) != 0);
    wr = ($urandom_range(0, 1) != 0);
    d  = 8'($urandom);
    if (k < 90)       a = 16'($urandom_range(0, 16'hFEFF));
    else if (k < 170) a = 16'h0000 | (16'hFF00 + 16'($urandom_range(0, 255)));
    else if (k < 198) begin
      a  = 16'hFF46;
      wr = 0;
    end else begin
      a  = 16'hFF46;
      en = 1;
      wr = 1;
      if ($urandom_range(0, 1) != 0) d = 8'hE0 | 8'($urandom_range(0, 31));
    end
    if (a == 16'hFF46 && k < 170) a = 16'hFF80;
    mcycle(en, wr, a, d);
  endtask

  initial begin
    // Reset state: outputs low even with a CPU high-bus access presented.
    cpu_mem_enable = 1;
    cpu_addr       = 16'hFF80;
    t_cycle        = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hi_enable", hi_enable, 0);
    check_eq("rst_dma_active", dma_active, 0);
    check_eq("rst_ext_enable", ext_enable, 0);
    check_eq("rst_oam_write", oam_write, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mcycle(1, 0, 16'hFF46, 8'h00);

    // Register readback
    mcycle(1, 1, 16'hFF46, 8'h8A);
    mcycle(1, 0, 16'hFF46, 8'h00);
    drain();

    // Basic transfer
    mcycle(1, 1, 16'hFF46, 8'hC1);
    drain();

    // Echo source page
    mcycle(1, 1, 16'hFF46, 8'hE2);
    drain();

    // Restart at idx 50
    mcycle(1, 1, 16'hFF46, 8'hC1);
    run_until_idx(8'd50);
    mcycle(1, 1, 16'hFF46, 8'hC3);
    drain();

    // New write coinciding with the final byte
    mcycle(1, 1, 16'hFF46, 8'hC4);
    run_until_idx(8'd159);
    mcycle(1, 1, 16'hFF46, 8'hC5);
    drain();

    // Reset in the middle of the idx-80 byte
    mcycle(1, 1, 16'hFF46, 8'hC1);
    run_until_idx(8'd80);
    cpu_mem_enable = 1;
    cpu_mem_write  = 0;
    cpu_addr       = 16'h0150;
    t_cycle        = 2'd3;
    @(negedge clk);
    check_eq("pre_rst_oam_write", oam_write, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_oam_write", oam_write, 0);
    check_eq("mid_rst_ext_enable", ext_enable, 0);
    check_eq("mid_rst_dma_active", dma_active, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sched.delete();
    m_src = 8'hFF;
    mcycle(1, 0, 16'hFF46, 8'h00);
    mcycle(0, 0, 16'h0000, 8'h00);

    // Randomized traffic with occasional DMA starts and restarts
    repeat (3000) rand_op();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
